// File: rtl/efuse_pgm.sv
// eFuse program controller: latches a word and blows each '1' bit into the
// selected segment of the 256-bit array, one timed aen pulse per bit.
module efuse_pgm #(
  parameter  int NW   = 64,
  parameter  int WSEL = 256 / NW,
  localparam int SELW = (WSEL > 1) ? $clog2(WSEL) : 1,
  localparam int IW   = (NW > 1) ? $clog2(NW) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      rg_efuse_tpgm,
  input  logic [7:0]      rg_efuse_key,
  input  logic [SELW-1:0] write_sel,
  input  logic            write_start,
  input  logic [NW-1:0]   write_data,
  output logic            write_done,
  output logic            write_err,
  output logic            busy_pgm,
  output logic            efuse_pgmen_o,
  output logic            efuse_rden_o,
  output logic            efuse_aen_o,
  output logic [7:0]      efuse_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SETUP, S_PULSE, S_HOLD, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [NW-1:0]   data_q, data_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [7:0]      tpgm_q, tpgm_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            pgmen_q, pgmen_d;
  logic            aen_q, aen_d;
  logic [7:0]      addr_q, addr_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            last_s;
  logic [7:0]      addr_calc_s;

  assign last_s      = (idx_q == IW'(NW - 1));
  assign addr_calc_s = 8'((32'(sel_q) * NW) + 32'(idx_q));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    tpgm_d  = tpgm_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (write_start) begin
          if (rg_efuse_key == 8'hA5) begin
            data_d  = write_data;
            sel_d   = write_sel;
            tpgm_d  = (rg_efuse_tpgm == 8'd0) ? 8'd1 : rg_efuse_tpgm;
            idx_d   = '0;
            state_d = S_SCAN;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SCAN: begin
        if (data_q[idx_q]) begin
          state_d = S_SETUP;
        end else if (last_s) begin
          state_d = S_FINISH;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_SETUP: begin
        state_d = S_PULSE;
        cnt_d   = tpgm_q - 8'd1;
      end
      S_PULSE: begin
        if (cnt_q == 8'd0) begin
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_HOLD: begin
        if (last_s) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + IW'(1);
          state_d = S_SCAN;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they belong to; pgmen is sticky across SCAN once raised.
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FINISH);
    case (state_d)
      S_SETUP, S_HOLD: begin
        pgmen_d = 1'b1;
        aen_d   = 1'b0;
        addr_d  = addr_calc_s;
      end
      S_PULSE: begin
        pgmen_d = 1'b1;
        aen_d   = 1'b1;
        addr_d  = addr_calc_s;
      end
      S_SCAN: begin
        pgmen_d = pgmen_q;
        aen_d   = 1'b0;
        addr_d  = addr_q;
      end
      default: begin
        pgmen_d = 1'b0;
        aen_d   = 1'b0;
        addr_d  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      sel_q   <= '0;
      tpgm_q  <= 8'd0;
      idx_q   <= '0;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
      pgmen_q <= 1'b0;
      aen_q   <= 1'b0;
      addr_q  <= 8'd0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      tpgm_q  <= tpgm_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      pgmen_q <= pgmen_d;
      aen_q   <= aen_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign write_done    = done_q;
  assign write_err     = err_q;
  assign busy_pgm      = busy_q;
  assign efuse_pgmen_o = pgmen_q;
  assign efuse_rden_o  = 1'b0;
  assign efuse_aen_o   = aen_q;
  assign efuse_addr_o  = addr_q;

endmodule
